// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two register operands from the bank with same-cycle write forwarding
// and presents them to the ALU through a 2-entry buffer whose held entries snoop later bank writes.
module operand_fetch #(
   parameter int unsigned NREGS = 16,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NREGS*WIDTH-1:0] regs_flat_i,
   input  logic [NREGS-1:0]       wr_en_i,
   input  logic [WIDTH-1:0]       wr_data_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AW-1:0]          rs_addr_i,
   input  logic [AW-1:0]          rt_addr_i,
   output logic                   op_valid_o,
   input  logic                   op_ready_i,
   output logic [WIDTH-1:0]       op_a_o,
   output logic [WIDTH-1:0]       op_b_o,
   output logic [AW-1:0]          op_rs_o,
   output logic [AW-1:0]          op_rt_o,
   output logic                   err_multi_o
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q  [2];
   logic [WIDTH-1:0] a_d  [2];
   logic [WIDTH-1:0] b_q  [2];
   logic [WIDTH-1:0] b_d  [2];
   logic [AW-1:0]    rs_q [2];
   logic [AW-1:0]    rs_d [2];
   logic [AW-1:0]    rt_q [2];
   logic [AW-1:0]    rt_d [2];
   logic             err_q, err_d;

   logic             push, pop, multi;
   logic [WIDTH-1:0] cap_a, cap_b;
   logic [WIDTH-1:0] snp_a [2];
   logic [WIDTH-1:0] snp_b [2];

   // Capture with forwarding, plus the snooped view of every held slot.
   always_comb begin
      cap_a = wr_en_i[rs_addr_i] ? wr_data_i : regs_flat_i[rs_addr_i*WIDTH +: WIDTH];
      cap_b = wr_en_i[rt_addr_i] ? wr_data_i : regs_flat_i[rt_addr_i*WIDTH +: WIDTH];
      for (int i = 0; i < 2; i++) begin
         snp_a[i] = wr_en_i[rs_q[i]] ? wr_data_i : a_q[i];
         snp_b[i] = wr_en_i[rt_q[i]] ? wr_data_i : b_q[i];
      end
   end

   assign push  = req_valid_i & (state_q != StTwo);
   assign pop   = (state_q != StEmpty) & op_ready_i;
   assign multi = |(wr_en_i & (wr_en_i - NREGS'(1)));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      err_d   = err_q | multi;
      unique case (state_q)
         StEmpty: begin
            if (push) begin
               a_d[0]  = cap_a;
               b_d[0]  = cap_b;
               rs_d[0] = rs_addr_i;
               rt_d[0] = rt_addr_i;
               state_d = StOne;
            end
         end
         StOne: begin
            if (push && pop) begin
               a_d[0]  = cap_a;
               b_d[0]  = cap_b;
               rs_d[0] = rs_addr_i;
               rt_d[0] = rt_addr_i;
            end else if (push) begin
               a_d[0]  = snp_a[0];
               b_d[0]  = snp_b[0];
               a_d[1]  = cap_a;
               b_d[1]  = cap_b;
               rs_d[1] = rs_addr_i;
               rt_d[1] = rt_addr_i;
               state_d = StTwo;
            end else if (pop) begin
               state_d = StEmpty;
            end else begin
               a_d[0] = snp_a[0];
               b_d[0] = snp_b[0];
            end
         end
         StTwo: begin
            if (pop) begin
               // Second entry moves to the head and still snoops this edge.
               a_d[0]  = snp_a[1];
               b_d[0]  = snp_b[1];
               rs_d[0] = rs_q[1];
               rt_d[0] = rt_q[1];
               state_d = StOne;
            end else begin
               a_d[0] = snp_a[0];
               b_d[0] = snp_b[0];
               a_d[1] = snp_a[1];
               b_d[1] = snp_b[1];
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StEmpty;
         err_q   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            a_q[i]  <= '0;
            b_q[i]  <= '0;
            rs_q[i] <= '0;
            rt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
      end
   end

   assign req_ready_o = (state_q != StTwo);
   assign op_valid_o  = (state_q != StEmpty);
   assign op_a_o      = a_q[0];
   assign op_b_o      = b_q[0];
   assign op_rs_o     = rs_q[0];
   assign op_rt_o     = rt_q[0];
   assign err_multi_o = err_q;

endmodule
